// File: rtl/qbus_ram_slave.sv
// Q-bus (MPI) RAM responder: latches the address on SYNC, decodes a RAM window and answers
// DIN reads and DOUT word/byte writes with RPLY after a programmable delay.
module qbus_ram_slave #(
  parameter int          AW       = 12,
  parameter logic [21:0] BASE     = 22'h000000,
  parameter int          RPLY_DLY = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_bus_init_n,
  input  logic [5:0]  i_bus_a_n,
  input  logic [15:0] i_bus_ad_in_n,
  output logic [15:0] o_bus_ad_out_n,
  output logic        o_bus_ad_oe,
  input  logic        i_bus_sync_n,
  input  logic        i_bus_din_n,
  input  logic        i_bus_dout_n,
  input  logic        i_bus_wtbt_n,
  input  logic        i_bus_iako_n,
  output logic        o_bus_rply_n,
  output logic        o_sel
);

  typedef enum logic [2:0] {IDLE, ADDR, RD, WR, RHLD, WHLD} state_t;

  state_t          r_state;
  logic [5:0]      r_a_n;
  logic [15:0]     r_ad_n;
  logic            r_sync_n, r_sync_d, r_din_n, r_dout_n, r_wtbt_n, r_iako_n;
  logic            r_rply_n, r_ad_oe, r_sel, r_byte;
  logic [15:0]     r_ad_out_n;
  logic [3:0]      r_cnt;
  logic [AW-1:0]   r_word;
  logic [15:0]     r_mem [0:(2**AW)-1];

  logic            w_reset;
  logic [21:0]     w_addr;
  logic            w_hit;
  logic            w_rd_go, w_wr_go;
  logic [15:0]     w_wdata, w_rdata;

  // Sampling flops are deliberately not reset so a SYNC held low across reset is not seen as a new fall.
  always_ff @(posedge i_clk) begin
    r_a_n    <= i_bus_a_n;
    r_ad_n   <= i_bus_ad_in_n;
    r_sync_n <= i_bus_sync_n;
    r_sync_d <= r_sync_n;
    r_din_n  <= i_bus_din_n;
    r_dout_n <= i_bus_dout_n;
    r_wtbt_n <= i_bus_wtbt_n;
    r_iako_n <= i_bus_iako_n;
  end

  assign w_reset = !i_rst_n || !i_bus_init_n;
  assign w_addr  = ~{r_a_n, r_ad_n};
  assign w_hit   = (w_addr[21:AW+1] == BASE[21:AW+1]) && r_iako_n;
  assign w_wdata = ~r_ad_n;
  assign w_rdata = r_mem[r_word];

  assign w_rd_go = (r_state == ADDR) && !r_sync_n && r_sel && !r_din_n && r_dout_n && !w_reset;
  assign w_wr_go = (r_state == ADDR) && !r_sync_n && r_sel && !r_dout_n && r_din_n && !w_reset;

  // The write commits on the edge the DOUT strobe is accepted, so later aborts cannot undo it.
  always_ff @(posedge i_clk) begin
    if (w_wr_go) begin
      if (r_wtbt_n)
        r_mem[r_word] <= w_wdata;
      else if (r_byte)
        r_mem[r_word][15:8] <= w_wdata[15:8];
      else
        r_mem[r_word][7:0] <= w_wdata[7:0];
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_reset) begin
      r_state    <= IDLE;
      r_rply_n   <= 1'b1;
      r_ad_oe    <= 1'b0;
      r_ad_out_n <= 16'hFFFF;
      r_sel      <= 1'b0;
      r_cnt      <= 4'd0;
      r_word     <= '0;
      r_byte     <= 1'b0;
    end else if (r_state != IDLE && r_sync_n) begin
      r_state    <= IDLE;
      r_rply_n   <= 1'b1;
      r_ad_oe    <= 1'b0;
      r_ad_out_n <= 16'hFFFF;
      r_sel      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (r_sync_d && !r_sync_n) begin
            r_state <= ADDR;
            r_sel   <= w_hit;
            r_word  <= w_addr[AW:1];
            r_byte  <= w_addr[0];
          end
        end
        ADDR: begin
          if (w_rd_go) begin
            if (RPLY_DLY <= 1) begin
              r_ad_out_n <= ~w_rdata;
              r_ad_oe    <= 1'b1;
              r_rply_n   <= 1'b0;
              r_state    <= RHLD;
            end else begin
              r_cnt   <= 4'(RPLY_DLY - 1);
              r_state <= RD;
            end
          end else if (w_wr_go) begin
            if (RPLY_DLY <= 1) begin
              r_rply_n <= 1'b0;
              r_state  <= WHLD;
            end else begin
              r_cnt   <= 4'(RPLY_DLY - 1);
              r_state <= WR;
            end
          end
        end
        RD: begin
          if (r_din_n) begin
            r_state <= ADDR;
          end else if (r_cnt <= 4'd1) begin
            r_ad_out_n <= ~w_rdata;
            r_ad_oe    <= 1'b1;
            r_rply_n   <= 1'b0;
            r_state    <= RHLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        WR: begin
          if (r_dout_n) begin
            r_state <= ADDR;
          end else if (r_cnt <= 4'd1) begin
            r_rply_n <= 1'b0;
            r_state  <= WHLD;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        RHLD: begin
          if (r_din_n) begin
            r_rply_n   <= 1'b1;
            r_ad_oe    <= 1'b0;
            r_ad_out_n <= 16'hFFFF;
            r_state    <= ADDR;
          end
        end
        WHLD: begin
          if (r_dout_n) begin
            r_rply_n <= 1'b1;
            r_state  <= ADDR;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign o_bus_ad_out_n = r_ad_out_n;
  assign o_bus_ad_oe    = r_ad_oe;
  assign o_bus_rply_n   = r_rply_n;
  assign o_sel          = r_sel;

endmodule

// File: tb/tb_qbus_ram_slave.sv
// Scoreboard bench for qbus_ram_slave: directed bus cycles push expected replies, a monitor
// pops and compares each time RPLY asserts.
module tb_qbus_ram_slave;

  localparam int RPLY_DLY = 2;

  typedef struct {
    logic        isRead;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rstN, initN;
  logic [5:0]  aN;
  logic [15:0] adInN, adOutN;
  logic        adOe, syncN, dinN, doutN, wtbtN, iakoN, rplyN, sel;

  exp_t        expQ[$];
  int          checks = 0;
  int          failures = 0;

  qbus_ram_slave #(.AW(12), .BASE(22'h000000), .RPLY_DLY(RPLY_DLY)) dut (
    .i_clk(clk), .i_rst_n(rstN), .i_bus_init_n(initN), .i_bus_a_n(aN),
    .i_bus_ad_in_n(adInN), .o_bus_ad_out_n(adOutN), .o_bus_ad_oe(adOe),
    .i_bus_sync_n(syncN), .i_bus_din_n(dinN), .i_bus_dout_n(doutN),
    .i_bus_wtbt_n(wtbtN), .i_bus_iako_n(iakoN), .o_bus_rply_n(rplyN), .o_sel(sel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic startCycle(input logic [21:0] addr);
    @(negedge clk);
    aN    = ~addr[21:16];
    adInN = ~addr[15:0];
    @(negedge clk);
    syncN = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic endCycle();
    syncN = 1'b1;
    aN    = 6'h3F;
    adInN = 16'hFFFF;
    repeat (3) @(negedge clk);
  endtask

  // Issues one data strobe inside an open cycle, checks reply latency and release.
  task automatic applyStimulus(input logic isWrite, input logic [15:0] data, input logic byteWrite);
    exp_t e;
    int   n;
    e.isRead = !isWrite;
    e.data   = data;
    expQ.push_back(e);
    if (isWrite) begin
      adInN = ~data;
      wtbtN = !byteWrite;
      doutN = 1'b0;
    end else begin
      adInN = 16'hFFFF;
      dinN  = 1'b0;
    end
    n = 0;
    while (n < 20) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (rplyN === 1'b0) break;
    end
    checkOutput("rply_latency", n, RPLY_DLY + 1);
    dinN  = 1'b1;
    doutN = 1'b1;
    wtbtN = 1'b1;
    adInN = 16'hFFFF;
    n = 0;
    while (n < 20 && rplyN !== 1'b1) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rply_release_timeout", (n >= 20), 0);
    checkOutput("oe_after_release", adOe, 0);
  endtask

  task automatic doWrite(input logic [21:0] addr, input logic [15:0] data, input logic byteWrite);
    startCycle(addr);
    applyStimulus(1'b1, data, byteWrite);
    endCycle();
  endtask

  task automatic doRead(input logic [21:0] addr, input logic [15:0] data);
    startCycle(addr);
    applyStimulus(1'b0, data, 1'b0);
    endCycle();
  endtask

  // Monitor: compares each new RPLY against the head of the scoreboard.
  initial begin
    logic prevLow, lowNow;
    logic [15:0] rd;
    exp_t e;
    prevLow = 1'b0;
    forever begin
      @(negedge clk);
      lowNow = (rplyN === 1'b0);
      if (adOe === 1'b1) checkOutput("oe_only_with_rply", rplyN, 0);
      if (lowNow && !prevLow) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpected_rply", 1, 0);
        end else begin
          e = expQ.pop_front();
          if (e.isRead) begin
            rd = ~adOutN;
            checkOutput("read_data", rd, e.data);
            checkOutput("read_oe", adOe, 1);
          end else begin
            checkOutput("write_oe", adOe, 0);
          end
        end
      end
      prevLow = lowNow;
    end
  end

  initial begin
    logic bad;
    int   n;
    rstN = 1'b0; initN = 1'b1; aN = 6'h3F; adInN = 16'hFFFF;
    syncN = 1'b1; dinN = 1'b1; doutN = 1'b1; wtbtN = 1'b1; iakoN = 1'b1;

    repeat (2) @(negedge clk);
    checkOutput("reset_rply", rplyN, 1);
    checkOutput("reset_oe", adOe, 0);
    checkOutput("reset_adout", adOutN, 16'hFFFF);
    checkOutput("reset_sel", sel, 0);
    rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] word write/read");
    startCycle(22'h000100);
    checkOutput("sel_in_window", sel, 1);
    applyStimulus(1'b1, 16'o123456, 1'b0);
    endCycle();
    doRead(22'h000100, 16'o123456);

    $display("[TB] byte write high lane");
    doWrite(22'h000100, 16'h1234, 1'b0);
    doWrite(22'h000101, 16'hA500, 1'b1);
    doRead(22'h000100, 16'hA534);
    doWrite(22'h000102, 16'h5678, 1'b0);
    doWrite(22'h000102, 16'h00C3, 1'b1);
    doRead(22'h000102, 16'h56C3);

    $display("[TB] out-of-window access");
    startCycle(22'h004000);
    checkOutput("oow_sel", sel, 0);
    dinN = 1'b0;
    bad = 1'b0;
    repeat (64) begin
      @(negedge clk);
      if (rplyN !== 1'b1 || adOe !== 1'b0) bad = 1'b1;
    end
    checkOutput("oow_read_quiet", bad, 0);
    dinN = 1'b1;
    endCycle();
    startCycle(22'h004100);
    adInN = ~16'hDEAD;
    doutN = 1'b0;
    bad = 1'b0;
    repeat (16) begin
      @(negedge clk);
      if (rplyN !== 1'b1) bad = 1'b1;
    end
    checkOutput("oow_write_quiet", bad, 0);
    doutN = 1'b1;
    endCycle();
    doRead(22'h000100, 16'hA534);

    $display("[TB] read-modify-write");
    doWrite(22'h000200, 16'h0001, 1'b0);
    startCycle(22'h000200);
    applyStimulus(1'b0, 16'h0001, 1'b0);
    applyStimulus(1'b1, 16'h0002, 1'b0);
    endCycle();
    doRead(22'h000200, 16'h0002);

    $display("[TB] reset during read hold");
    doWrite(22'h000300, 16'hBEEF, 1'b0);
    startCycle(22'h000300);
    begin
      exp_t e;
      e.isRead = 1'b1;
      e.data   = 16'hBEEF;
      expQ.push_back(e);
    end
    dinN = 1'b0;
    n = 0;
    while (n < 20 && rplyN !== 1'b0) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rhld_reach_timeout", (n >= 20), 0);
    rstN = 1'b0;
    @(negedge clk);
    checkOutput("rst_rply_released", rplyN, 1);
    checkOutput("rst_oe_released", adOe, 0);
    checkOutput("rst_sel_cleared", sel, 0);
    rstN = 1'b1;
    bad = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (rplyN !== 1'b1 || adOe !== 1'b0) bad = 1'b1;
    end
    checkOutput("aborted_no_reply", bad, 0);
    dinN = 1'b1;
    endCycle();
    doRead(22'h000300, 16'hBEEF);
    doRead(22'h000200, 16'h0002);

    repeat (4) @(negedge clk);
    checkOutput("scoreboard_empty", expQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
